// File: rtl/ir_key_decoder_pkg.sv
// ir_key_pkg: shared key code table, key index names and decoder FSM state type
package ir_key_pkg;
  localparam int KEY_TABLE_N = 15;
  localparam logic [7:0] KEY_CODES [KEY_TABLE_N] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'hA0, 8'h83, 8'hC6, 8'hA1, 8'h86
  };
  localparam int KEY_PREV  = 10;
  localparam int KEY_NEXT  = 11;
  localparam int KEY_PLAY  = 12;
  localparam int KEY_VOLDN = 13;
  localparam int KEY_VOLUP = 14;
  typedef enum logic [1:0] {IDLE, QUALIFY, PRESSED, HELD_NOREP} state_t;
endpackage

// File: rtl/ir_key_decoder_lookup.sv
// ir_key_lookup: priority match of a code against KEY_CODES (code in; hit, idx out)
module ir_key_lookup
  import ir_key_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int NUM_KEYS = 15,
  parameter int IDX_W = 4
) (
  input  logic [CODE_W-1:0] code,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (code == CODE_W'(KEY_CODES[i])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
  end
endmodule

// File: rtl/ir_key_decoder.sv
// ir_key_decoder: qualifies led_db codes and emits one pulse per press, auto-repeats and press toggles
// ports: clk, reset (sync, active high), led_db code in; key_pulse, key_idx, key_held,
// key_repeat, unknown_pulse, toggle out. IR_KEY_TOGGLE_EN builds the toggle flops.
module ir_key_decoder
  import ir_key_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int NUM_KEYS = 15,
  parameter logic [CODE_W-1:0] IDLE_CODE = CODE_W'(8'hFF),
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_PERIOD = 100000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK = NUM_KEYS'(15'h6000),
  parameter int TOGGLE0_KEY = 1,
  parameter int TOGGLE1_KEY = 14,
  localparam int IDX_W = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CODE_W-1:0]   led_db,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [IDX_W-1:0]    key_idx,
  output logic                key_held,
  output logic                key_repeat,
  output logic                unknown_pulse,
  output logic [1:0]          toggle
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int REP_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W = $clog2(REP_MAX + 1);
  localparam logic [CNT_W-1:0] SC = CNT_W'(STABLE_CYCLES);
  localparam logic [REP_W-1:0] RD = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] RP = REP_W'(REPEAT_PERIOD);
  localparam logic [REP_W-1:0] RM = REP_W'(REP_MAX);
  state_t state_q, state_d;
  logic [CODE_W-1:0] sample_q, prev_q;
  logic [CNT_W-1:0] stable_q, stable_d, stable_inc;
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  logic first_q, first_d;
  logic [NUM_KEYS-1:0] pulse_d;
  logic [IDX_W-1:0] idx_d, lk_idx;
  logic held_d, repeat_d, unknown_d, lk_hit, idle_in, same, accept;
  logic [1:0] tog_hit;
  ir_key_lookup #(.CODE_W(CODE_W), .NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) u_lookup (
    .code(sample_q),
    .hit(lk_hit),
    .idx(lk_idx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sample_q <= IDLE_CODE;
      prev_q <= IDLE_CODE;
      stable_q <= '0;
      rep_q <= '0;
      first_q <= 1'b0;
      key_pulse <= '0;
      key_idx <= '0;
      key_held <= 1'b0;
      key_repeat <= 1'b0;
      unknown_pulse <= 1'b0;
    end else begin
      state_q <= state_d;
      sample_q <= led_db;
      prev_q <= sample_q;
      stable_q <= stable_d;
      rep_q <= rep_d;
      first_q <= first_d;
      key_pulse <= pulse_d;
      key_idx <= idx_d;
      key_held <= held_d;
      key_repeat <= repeat_d;
      unknown_pulse <= unknown_d;
    end
  end
  always_comb begin
    idle_in = sample_q == IDLE_CODE;
    same = sample_q == prev_q;
    stable_inc = stable_q == SC ? stable_q : stable_q + 1'b1;
    rep_inc = rep_q == RM ? rep_q : rep_q + 1'b1;
    state_d = state_q;
    stable_d = stable_q;
    rep_d = rep_q;
    first_d = first_q;
    pulse_d = '0;
    idx_d = key_idx;
    held_d = key_held;
    repeat_d = 1'b0;
    unknown_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = idle_in ? IDLE : QUALIFY;
        stable_d = CNT_W'(1);
      end
      QUALIFY: begin
        state_d = idle_in ? IDLE : QUALIFY;
        stable_d = same ? stable_inc : CNT_W'(1);
      end
      default:
        if (idle_in || !same) begin
          state_d = idle_in ? IDLE : QUALIFY;
          stable_d = CNT_W'(1);
          held_d = 1'b0;
        end else if (state_q == PRESSED) begin
          rep_d = rep_inc;
          if (rep_inc == (first_q ? RD : RP)) begin
            pulse_d = NUM_KEYS'(1) << key_idx;
            repeat_d = 1'b1;
            rep_d = '0;
            first_d = 1'b0;
          end
        end
    endcase
    // a code that reaches the stability count in this cycle is accepted, whichever state it came from
    accept = state_d == QUALIFY && stable_d >= SC;
    if (accept) begin
      state_d = lk_hit && REPEAT_MASK[lk_idx] ? PRESSED : HELD_NOREP;
      stable_d = '0;
      rep_d = '0;
      first_d = 1'b1;
      held_d = lk_hit;
      unknown_d = !lk_hit;
      pulse_d = lk_hit ? NUM_KEYS'(1) << lk_idx : '0;
      idx_d = lk_hit ? lk_idx : key_idx;
    end
    tog_hit = {accept && lk_hit && lk_idx == IDX_W'(TOGGLE1_KEY),
               accept && lk_hit && lk_idx == IDX_W'(TOGGLE0_KEY)};
  end
`ifdef IR_KEY_TOGGLE_EN
  always_ff @(posedge clk) toggle <= reset ? 2'b00 : toggle ^ tog_hit;
`else
  assign toggle = tog_hit & 2'b00;
`endif
endmodule

// File: tb/tb_ir_key_decoder.sv
// tb_ir_key_decoder: scoreboard bench for ir_key_decoder with short repeat timing
module tb_ir_key_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] led_db = 8'hFF;
  logic [14:0] key_pulse;
  logic [3:0] key_idx;
  logic key_held, key_repeat, unknown_pulse;
  logic [1:0] toggle;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [1:0] tog_exp = 2'b00;
  typedef struct {int cyc; int idx; bit rep;} ev_t;
  ev_t sb[$];
`ifdef IR_KEY_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif
  ir_key_decoder #(.STABLE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .clk(clk),
    .reset(reset),
    .led_db(led_db),
    .key_pulse(key_pulse),
    .key_idx(key_idx),
    .key_held(key_held),
    .key_repeat(key_repeat),
    .unknown_pulse(unknown_pulse),
    .toggle(toggle)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int hot(logic [14:0] v);
    for (int i = 0; i < 15; i++)
      if (v[i]) return i;
    return -2;
  endfunction
  task automatic expect_ev(int c, int rel, int idx, bit rep);
    sb.push_back('{c + 1 + rel, idx, rep});
  endtask
  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    ev_t e;
    int idx;
    if (key_pulse != 15'd0 || unknown_pulse) begin
      idx = unknown_pulse ? -1 : hot(key_pulse);
      check("onehot", $countones({key_pulse, unknown_pulse}), 1);
      if (sb.size() == 0)
        check("unexpected_pulse_cycle", cyc, -1);
      else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_idx", idx, e.idx);
        check("pulse_repeat", int'(key_repeat), int'(e.rep));
        if (!unknown_pulse) check("pulse_key_idx", int'(key_idx), e.idx);
      end
    end else
      check("stray_repeat", int'(key_repeat), 0);
  end
  initial begin
    int c, r;
    wait_n(3);
    check("rst_pulse", int'(key_pulse), 0);
    check("rst_idx", int'(key_idx), 0);
    check("rst_held", int'(key_held), 0);
    check("rst_repeat", int'(key_repeat), 0);
    check("rst_unknown", int'(unknown_pulse), 0);
    check("rst_toggle", int'(toggle), 0);
    reset = 1'b0;
    wait_n(2);
    led_db = 8'hA4;
    c = cyc;
    expect_ev(c, 4, 2, 1'b0);
    wait_n(4);
    check("s1_held_before", int'(key_held), 0);
    wait_n(1);
    check("s1_held", int'(key_held), 1);
    wait_n(45);
    check("s1_held_late", int'(key_held), 1);
    led_db = 8'hFF;
    wait_n(1);
    check("s1_held_release_minus", int'(key_held), 1);
    wait_n(1);
    check("s1_held_released", int'(key_held), 0);
    check("s1_toggle", int'(toggle), int'(TOG_EN ? tog_exp : 2'b00));
    wait_n(4);
    check("s1_left", sb.size(), 0);
    led_db = 8'h86;
    c = cyc;
    expect_ev(c, 4, 14, 1'b0);
    for (int k = 24; k <= 48; k += 8) expect_ev(c, k, 14, 1'b1);
    tog_exp ^= 2'b10;
    wait_n(50);
    check("s2_held", int'(key_held), 1);
    check("s2_toggle", int'(toggle), int'(TOG_EN ? tog_exp : 2'b00));
    led_db = 8'hFF;
    wait_n(6);
    check("s2_released", int'(key_held), 0);
    check("s2_left", sb.size(), 0);
    led_db = 8'hC0;
    wait_n(3);
    led_db = 8'hFF;
    wait_n(2);
    check("s3_held", int'(key_held), 0);
    wait_n(6);
    check("s3_held_late", int'(key_held), 0);
    check("s3_left", sb.size(), 0);
    led_db = 8'h55;
    c = cyc;
    expect_ev(c, 4, -1, 1'b0);
    wait_n(6);
    check("s4_held", int'(key_held), 0);
    wait_n(4);
    led_db = 8'hFF;
    wait_n(4);
    check("s4_left", sb.size(), 0);
    led_db = 8'hF9;
    c = cyc;
    expect_ev(c, 4, 1, 1'b0);
    tog_exp ^= 2'b01;
    wait_n(10);
    check("s5_held_first", int'(key_held), 1);
    led_db = 8'hA0;
    r = cyc;
    expect_ev(r, 4, 10, 1'b0);
    wait_n(3);
    check("s5_held_switch", int'(key_held), 0);
    wait_n(3);
    check("s5_held_second", int'(key_held), 1);
    check("s5_idx", int'(key_idx), 10);
    check("s5_toggle", int'(toggle), int'(TOG_EN ? tog_exp : 2'b00));
    led_db = 8'hFF;
    wait_n(4);
    check("s5_left", sb.size(), 0);
    led_db = 8'hA1;
    c = cyc;
    expect_ev(c, 4, 13, 1'b0);
    expect_ev(c, 24, 13, 1'b1);
    wait_n(30);
    reset = 1'b1;
    wait_n(1);
    check("s6_rst_pulse", int'(key_pulse), 0);
    check("s6_rst_idx", int'(key_idx), 0);
    check("s6_rst_held", int'(key_held), 0);
    check("s6_rst_repeat", int'(key_repeat), 0);
    check("s6_rst_unknown", int'(unknown_pulse), 0);
    check("s6_rst_toggle", int'(toggle), 0);
    tog_exp = 2'b00;
    wait_n(1);
    reset = 1'b0;
    r = cyc;
    expect_ev(r, 4, 13, 1'b0);
    wait_n(8);
    check("s6_held", int'(key_held), 1);
    check("s6_toggle", int'(toggle), int'(TOG_EN ? tog_exp : 2'b00));
    led_db = 8'hFF;
    wait_n(4);
    check("s6_left", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ir_key_decoder.md
# ir_key_decoder

- Parametrised IR-remote key decoder. Takes the decoder's 8-bit seven-segment code bus and emits one-cycle key pulses.
- Adds behaviour the first generation lacked:
  - input qualification: a code must be stable before it is accepted.
  - one pulse per press instead of one per clock.
  - configurable auto-repeat for held keys.
  - toggles that flip once per press.
- Sits between the IR receiver/decoder and the player control logic (digit entry, PREV/NEXT/PLAY, volume).

## Interface
- CODE_W, 8: width of the incoming code bus.
- NUM_KEYS, 15: number of table entries; key index i maps to KEY_CODES[i] from the package.
- IDLE_CODE, 8'hFF: code meaning "no key"; never matched as a key.
- STABLE_CYCLES, 4: consecutive identical samples required to accept a code; must be ≥1.
- REPEAT_DELAY, 500000: cycles from the initial pulse to the first repeat pulse.
- REPEAT_PERIOD, 100000: cycles between later repeat pulses; must be ≥1.
- REPEAT_MASK, 15'h6000: bit i set means key i auto-repeats. The default is VOL- and VOL+.
- TOGGLE0_KEY, 1 and TOGGLE1_KEY, 14: key indices that flip toggle[0] and toggle[1].
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- led_db  in  CODE_W  code from the IR decoder, level-held while the button is held.
- key_pulse  out  NUM_KEYS  one-hot, one-cycle pulse per accepted press or repeat.
- key_idx  out  $clog2(NUM_KEYS)  index of the current or last accepted key. Valid while key_held is high.
- key_held  out  1  high while an accepted table key remains stable on led_db.
- key_repeat  out  1  high in the same cycle as key_pulse when that pulse is an auto-repeat.
- unknown_pulse  out  1  one-cycle pulse when a non-idle code that is not in the table is accepted.
- toggle  out  2  toggle states.

## Operation
- led_db is registered once (sample_q). All decisions use sample_q.
- FSM states: IDLE, QUALIFY, PRESSED, HELD_NOREP.
  - IDLE: when sample_q ≠ IDLE_CODE, go to QUALIFY and load stable_cnt=1.
  - QUALIFY: if sample_q equals the previous sample, increment stable_cnt; otherwise reload it to 1 and stay in QUALIFY. A return to IDLE_CODE goes to IDLE.
  - Acceptance happens when stable_cnt reaches STABLE_CYCLES.
    - Code is in the table: pulse key_pulse[i], set key_idx=i and key_held=1. Go to PRESSED if REPEAT_MASK[i] is set, else HELD_NOREP.
    - Code is not in the table: pulse unknown_pulse and go to HELD_NOREP with key_held=0.
  - PRESSED:
    - rep_cnt counts from the initial pulse. At REPEAT_DELAY, pulse key_pulse[i] with key_repeat=1.
    - After that, pulse every REPEAT_PERIOD cycles.
  - PRESSED or HELD_NOREP:
    - If sample_q becomes IDLE_CODE, go to IDLE and clear key_held.
    - If sample_q changes to another non-idle code, go to QUALIFY with stable_cnt=1 and clear key_held. No release is required between keys.
- Toggles flip only on an initial accepted press of TOGGLE0_KEY or TOGGLE1_KEY. Repeats never flip them.
- Table lookup is a priority match; the lowest index wins on duplicate codes.
- Counter widths come from $clog2 of their maximum. Counters saturate and never wrap.

## Timing
- Reset values: key_pulse=0, key_idx=0, key_held=0, key_repeat=0, unknown_pulse=0, toggle=2'b00, state=IDLE.
- Internal reset values: sample_q=IDLE_CODE, counters 0.
- Latency, with a code applied before edge 0 and held: key_pulse is registered at edge STABLE_CYCLES and is high for exactly one cycle.
- key_held and the toggle change take effect at the same edge as key_pulse.
- First repeat pulse: REPEAT_DELAY cycles after the initial pulse. Later repeats: every REPEAT_PERIOD cycles.
- Release, or a code change to a different code: takes effect one edge after sample_q changes. No pulse is issued on release.
- A glitch shorter than STABLE_CYCLES produces no pulse.
- Reset during a press:
  - All outputs are cleared at the next edge.
  - A code still held after reset deasserts is treated as a new press and is accepted after STABLE_CYCLES.
- At most one bit of key_pulse, or unknown_pulse, is high in any cycle.

## Configuration
- IR_KEY_TOGGLE_EN defined: the toggle logic is built as described above.
- IR_KEY_TOGGLE_EN undefined:
  - toggle is tied to 2'b00.
  - TOGGLE0_KEY and TOGGLE1_KEY are ignored.
  - No toggle flops are synthesised.

## Structure
- Package ir_key_pkg holds:
  - KEY_CODES table: 0xC0, 0xF9, 0xA4, 0xB0, 0x99, 0x92, 0x82, 0xF8, 0x80, 0x90, 0xA0, 0x83, 0xC6, 0xA1, 0x86 for digits 0–9, PREV, NEXT, PLAY, VOL-, VOL+.
  - Named key index constants (KEY_PREV=10, KEY_NEXT=11, KEY_PLAY=12, KEY_VOLDN=13, KEY_VOLUP=14).
  - The FSM state enum.
- One sub-module, ir_key_lookup: combinational table match producing hit and index.

## Test plan
Benches use STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Hold 0xA4 for 50 cycles, then 0xFF: exactly one key_pulse[2] at edge 4; key_held high until the release edge; key_repeat never high.
- Hold 0x86 for 50 cycles: key_pulse[14] at edge 4, then repeats at edges 24, 32, 40, 48 with key_repeat=1; toggle[1] flips once.
- Glitch 0xC0 for 3 cycles, then 0xFF: no key_pulse and key_held stays 0.
- 0x55 held: unknown_pulse once at edge 4; key_held=0.
- 0xF9 held, then switched directly to 0xA0: key_pulse[1] followed by key_pulse[10] 4 edges after the switch; toggle[0]=1 and unchanged by the second key.
- Reset asserted during a held 0xA1 repeat: all outputs 0 at the next edge; after reset deasserts with the key still held, key_pulse[13] at edge 4. Rebuild without IR_KEY_TOGGLE_EN and confirm toggle stays 0.
